// File: rtl/axi_adc_lite_slave_if.sv
// AXI4-Lite bus bundle for the ADC register slave; signal names follow the AXI
// port naming so the bus reads the same as a flat port list would.
interface axi_adc_lite_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_adc_lite_slave.sv
// AXI4-Lite register slave for an ADC front end: control/scratch/config
// registers plus a captured-sample register and a saturating sample counter.
module axi_adc_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    axi_adc_lite_slave_if.slave           s_axi,
    input  logic [15:0]                   adc_data,
    input  logic                          adc_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0] adc_cfg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] adc_cfg1
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_RESP} rd_state_t;

    wr_state_t       wr_state;
    rd_state_t       rd_state;
    logic            aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]      b_resp, r_resp;
    logic [DW-1:0]   r_data;
    logic            capture_en;
    logic [DW-1:0]   scratch, cfg0, cfg1, count;
    logic [15:0]     sample;
    logic [2:0]      wr_idx, rd_idx;
    logic            wr_fire, wr_mapped, cnt_clr, cap_fire, rd_mapped;
    logic [DW-1:0]   rd_word;
    logic            unused_bits;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_word,
                                                  input logic [DW-1:0] wdata,
                                                  input logic [NB-1:0] strb);
        merge_bytes = old_word;
        for (int b = 0; b < NB; b++)
            if (strb[b]) merge_bytes[8*b +: 8] = wdata[8*b +: 8];
    endfunction

    assign wr_idx    = s_axi.S_AXI_AWADDR[4:2];
    assign rd_idx    = s_axi.S_AXI_ARADDR[4:2];
    assign wr_mapped = (wr_idx <= 3'd5);
    assign rd_mapped = (rd_idx <= 3'd5);
    assign wr_fire   = (wr_state == W_ACCEPT) && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign cnt_clr   = wr_fire && (wr_idx == 3'd0) && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[1];
    assign cap_fire  = capture_en && adc_valid;

    assign s_axi.S_AXI_AWREADY = aw_ready;
    assign s_axi.S_AXI_WREADY  = w_ready;
    assign s_axi.S_AXI_BVALID  = b_valid;
    assign s_axi.S_AXI_BRESP   = b_resp;
    assign s_axi.S_AXI_ARREADY = ar_ready;
    assign s_axi.S_AXI_RVALID  = r_valid;
    assign s_axi.S_AXI_RRESP   = r_resp;
    assign s_axi.S_AXI_RDATA   = r_data;
    assign adc_cfg0 = cfg0;
    assign adc_cfg1 = cfg1;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // cnt_clr reads back as zero; only capture_en is stored in CTRL
    always_comb begin
        rd_word = '0;
        case (rd_idx)
            3'd0:    rd_word = {{(DW-1){1'b0}}, capture_en};
            3'd1:    rd_word = scratch;
            3'd2:    rd_word = cfg0;
            3'd3:    rd_word = cfg1;
            3'd4:    rd_word = {{(DW-16){1'b0}}, sample};
            3'd5:    rd_word = count;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state   <= W_IDLE;
            aw_ready   <= 1'b0;
            w_ready    <= 1'b0;
            b_valid    <= 1'b0;
            b_resp     <= RESP_OKAY;
            capture_en <= 1'b0;
            scratch    <= '0;
            cfg0       <= '0;
            cfg1       <= '0;
            count      <= '0;
            sample     <= '0;
        end else begin
            // a coincident clear takes priority over a capture increment
            if (cnt_clr)
                count <= '0;
            else if (cap_fire && (count != '1))
                count <= count + DW'(1);
            if (cap_fire)
                sample <= adc_data;

            case (wr_state)
                W_IDLE: begin
                    if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !b_valid) begin
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                        wr_state <= W_ACCEPT;
                    end
                end
                W_ACCEPT: begin
                    aw_ready <= 1'b0;
                    w_ready  <= 1'b0;
                    if (wr_fire) begin
                        b_valid  <= 1'b1;
                        b_resp   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                        wr_state <= W_RESP;
                        case (wr_idx)
                            3'd0: if (s_axi.S_AXI_WSTRB[0]) capture_en <= s_axi.S_AXI_WDATA[0];
                            3'd1: scratch <= merge_bytes(scratch, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                            3'd2: cfg0 <= merge_bytes(cfg0, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                            3'd3: cfg1 <= merge_bytes(cfg1, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                            default: ;
                        endcase
                    end else begin
                        wr_state <= W_IDLE;
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        b_valid  <= 1'b0;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // read data is captured on the ARREADY edge so later captures cannot disturb it
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_resp   <= RESP_OKAY;
            r_data   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_axi.S_AXI_ARVALID && !r_valid) begin
                        ar_ready <= 1'b1;
                        rd_state <= R_ACCEPT;
                    end
                end
                R_ACCEPT: begin
                    ar_ready <= 1'b0;
                    if (s_axi.S_AXI_ARVALID) begin
                        r_valid  <= 1'b1;
                        r_data   <= rd_word;
                        r_resp   <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
                        rd_state <= R_RESP;
                    end else begin
                        rd_state <= R_IDLE;
                    end
                end
                R_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        r_valid  <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_adc_lite_slave.sv
// Directed bench for axi_adc_lite_slave: stimulus tasks queue expected B/R
// responses, and a negedge monitor pops and compares them at each handshake.
module tb_axi_adc_lite_slave;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk;
    logic        rst_n;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic [31:0] adc_cfg0;
    logic [31:0] adc_cfg1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [33:0] r_expected;

    axi_adc_lite_slave_if bus ();

    axi_adc_lite_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus.slave),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .adc_cfg0      (adc_cfg0),
        .adc_cfg1      (adc_cfg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: handshake timed out after 50 cycles", name);
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd0);
        check_output({tag, "_wready"},  32'(bus.S_AXI_WREADY),  32'd0);
        check_output({tag, "_bvalid"},  32'(bus.S_AXI_BVALID),  32'd0);
        check_output({tag, "_bresp"},   32'(bus.S_AXI_BRESP),   32'd0);
        check_output({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'd0);
        check_output({tag, "_rvalid"},  32'(bus.S_AXI_RVALID),  32'd0);
        check_output({tag, "_rresp"},   32'(bus.S_AXI_RRESP),   32'd0);
        check_output({tag, "_rdata"},   bus.S_AXI_RDATA,        32'd0);
        check_output({tag, "_cfg0"},    adc_cfg0,               32'd0);
        check_output({tag, "_cfg1"},    adc_cfg1,               32'd0);
    endtask

    // scoreboard monitor: one pop per completed B or R handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL b_unexpected: got bresp 0x%0h, expected no response", bus.S_AXI_BRESP);
                end else begin
                    check_output("bresp", 32'(bus.S_AXI_BRESP), 32'(exp_b.pop_front()));
                end
            end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL r_unexpected: got rdata 0x%08h, expected no response", bus.S_AXI_RDATA);
                end else begin
                    r_expected = exp_r.pop_front();
                    check_output("rdata", bus.S_AXI_RDATA, r_expected[33:2]);
                    check_output("rresp", 32'(bus.S_AXI_RRESP), 32'(r_expected[1:0]));
                end
            end
        end
    end

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input bit pulse = 1'b0,
                             input logic [15:0] pulse_data = 16'h0);
        int t;
        exp_b.push_back(resp);
        @(posedge clk); #1;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_AWREADY && t < 50);
        if (!bus.S_AXI_AWREADY) timeout_fail("aw_handshake");
        if (pulse) begin
            adc_data  = pulse_data;
            adc_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        adc_valid         = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_BVALID && t < 50);
        if (!bus.S_AXI_BVALID) timeout_fail("b_response");
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int t;
        exp_r.push_back({data, resp});
        @(posedge clk); #1;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_ARREADY && t < 50);
        if (!bus.S_AXI_ARREADY) timeout_fail("ar_handshake");
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_RVALID && t < 50);
        if (!bus.S_AXI_RVALID) timeout_fail("r_response");
        @(posedge clk); #1;
    endtask

    task automatic adc_pulse(input logic [15:0] data);
        @(posedge clk); #1;
        adc_data  = data;
        adc_valid = 1'b1;
        @(posedge clk); #1;
        adc_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at 100000 ns, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        adc_data = '0;
        adc_valid = 1'b0;
        bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk); #2;
        rst_n = 1'b1;

        // basic register write/readback and config mirrors
        axi_write(5'h00, 32'h1, 4'hF, OKAY);
        axi_write(5'h04, 32'h2, 4'hF, OKAY);
        axi_write(5'h08, 32'h3, 4'hF, OKAY);
        axi_write(5'h0C, 32'h4, 4'hF, OKAY);
        @(negedge clk);
        check_output("adc_cfg0", adc_cfg0, 32'h3);
        check_output("adc_cfg1", adc_cfg1, 32'h4);
        axi_read(5'h00, 32'h1, OKAY);
        axi_read(5'h04, 32'h2, OKAY);
        axi_read(5'h08, 32'h3, OKAY);
        axi_read(5'h0C, 32'h4, OKAY);
        axi_read(5'h0B, 32'h3, OKAY);

        // read and write to scratch accepted on the same edge: read sees old value
        fork
            axi_write(5'h04, 32'h12345678, 4'hF, OKAY);
            axi_read(5'h04, 32'h2, OKAY);
        join
        axi_read(5'h04, 32'h12345678, OKAY);

        // byte strobes
        axi_write(5'h04, 32'h0, 4'hF, OKAY);
        axi_write(5'h04, 32'hAABBCCDD, 4'b0101, OKAY);
        axi_read(5'h04, 32'h00BB00DD, OKAY);

        // sample capture with capture_en already set
        adc_pulse(16'h0123);
        adc_pulse(16'h0456);
        adc_pulse(16'h0789);
        axi_read(5'h10, 32'h00000789, OKAY);
        axi_read(5'h14, 32'd3, OKAY);
        axi_write(5'h00, 32'h3, 4'hF, OKAY);
        axi_read(5'h14, 32'd0, OKAY);
        axi_read(5'h00, 32'h1, OKAY);

        // clear coincident with a capture: sample updates, count stays 0
        axi_write(5'h00, 32'h3, 4'hF, OKAY, 1'b1, 16'h0ABC);
        axi_read(5'h14, 32'd0, OKAY);
        axi_read(5'h10, 32'h00000ABC, OKAY);
        adc_pulse(16'h0111);
        axi_read(5'h14, 32'd1, OKAY);

        // capture disabled: adc_valid ignored
        axi_write(5'h00, 32'h0, 4'hF, OKAY);
        adc_pulse(16'h0222);
        axi_read(5'h10, 32'h00000111, OKAY);
        axi_read(5'h14, 32'd1, OKAY);
        axi_read(5'h00, 32'h0, OKAY);

        // unmapped and read-only targets
        axi_write(5'h18, 32'hFFFFFFFF, 4'hF, SLVERR);
        axi_read(5'h18, 32'h0, SLVERR);
        axi_read(5'h1C, 32'h0, SLVERR);
        axi_write(5'h14, 32'hFFFFFFFF, 4'hF, OKAY);
        axi_read(5'h14, 32'd1, OKAY);
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, OKAY);
        axi_read(5'h10, 32'h00000111, OKAY);
        axi_read(5'h04, 32'h00BB00DD, OKAY);
        @(negedge clk);
        check_output("cfg0_after_bad_wr", adc_cfg0, 32'h3);
        check_output("cfg1_after_bad_wr", adc_cfg1, 32'h4);

        // stalled read of COUNT; a capture during the stall must not alter RDATA
        axi_write(5'h00, 32'h1, 4'hF, OKAY);
        exp_r.push_back({32'd1, OKAY});
        @(posedge clk); #1;
        bus.S_AXI_ARADDR  = 5'h14;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_ARREADY && t < 50);
        if (!bus.S_AXI_ARREADY) timeout_fail("stall_ar_handshake");
        @(posedge clk); #1;
        bus.S_AXI_ARADDR = 5'h04;
        adc_data  = 16'h0333;
        adc_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("stall_rvalid",  32'(bus.S_AXI_RVALID),  32'd1);
            check_output("stall_rdata",   bus.S_AXI_RDATA,        32'd1);
            check_output("stall_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
            @(posedge clk); #1;
            adc_valid = 1'b0;
        end
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        axi_read(5'h10, 32'h00000333, OKAY);
        axi_read(5'h14, 32'd2, OKAY);

        // stalled write response; config updates on the acceptance edge
        exp_b.push_back(OKAY);
        @(posedge clk); #1;
        bus.S_AXI_AWADDR  = 5'h0C;
        bus.S_AXI_WDATA   = 32'h55;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_AWREADY && t < 50);
        if (!bus.S_AXI_AWREADY) timeout_fail("stall_aw_handshake");
        @(posedge clk); #1;
        check_output("cfg1_no_latency", adc_cfg1, 32'h55);
        bus.S_AXI_AWADDR = 5'h08;
        bus.S_AXI_WDATA  = 32'h99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("stall_bvalid",  32'(bus.S_AXI_BVALID),  32'd1);
            check_output("stall_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
            check_output("stall_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
        end
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        check_output("cfg0_not_overwritten", adc_cfg0, 32'h3);

        // reset while BVALID is pending aborts the write response
        @(posedge clk); #1;
        bus.S_AXI_AWADDR  = 5'h04;
        bus.S_AXI_WDATA   = 32'hDEAD;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_AWREADY && t < 50);
        if (!bus.S_AXI_AWREADY) timeout_fail("abort_aw_handshake");
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        @(negedge clk);
        check_output("abort_bvalid_before", 32'(bus.S_AXI_BVALID), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        bus.S_AXI_BREADY = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("post_abort_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        end
        axi_write(5'h08, 32'h77, 4'hF, OKAY);
        @(negedge clk);
        check_output("fresh_cfg0", adc_cfg0, 32'h77);
        axi_read(5'h08, 32'h77, OKAY);
        axi_read(5'h04, 32'h0, OKAY);
        axi_read(5'h0C, 32'h0, OKAY);

        repeat (3) @(negedge clk);
        check_output("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check_output("r_queue_drained", 32'(exp_r.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_adc_lite_slave.md
AXI_ADC_LITE_SLAVE -- requirements
Module: axi_adc_lite_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, meaning byte address width (eight 32-bit word slots).
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- S_AXI_ACLK, in, 1, the single clock.
- S_AXI_ARESETN, in, 1, reset; asynchronous, active-low.
- S_AXI_AWADDR, in, 5; S_AXI_AWPROT, in, 3 (ignored); S_AXI_AWVALID, in, 1; S_AXI_AWREADY, out, 1.
- S_AXI_WDATA, in, 32; S_AXI_WSTRB, in, 4; S_AXI_WVALID, in, 1; S_AXI_WREADY, out, 1.
- S_AXI_BRESP, out, 2; S_AXI_BVALID, out, 1; S_AXI_BREADY, in, 1.
- S_AXI_ARADDR, in, 5; S_AXI_ARPROT, in, 3 (ignored); S_AXI_ARVALID, in, 1; S_AXI_ARREADY, out, 1.
- S_AXI_RDATA, out, 32; S_AXI_RRESP, out, 2; S_AXI_RVALID, out, 1; S_AXI_RREADY, in, 1.
- adc_data, in, 16, ADC sample.
- adc_valid, in, 1, sample strobe, single cycle per sample.
- adc_cfg0, out, 32, mirror of REG2.
- adc_cfg1, out, 32, mirror of REG3.

Function
REQ-004 SHALL decode word index = ADDR[4:2]; ADDR[1:0] ignored.
REQ-005 Register map SHALL be:
- REG0 0x00 CTRL RW: bit0 capture_en; bit1 cnt_clr, write-1 pulse, reads 0.
- REG1 0x04 SCRATCH RW.
- REG2 0x08 CFG0 RW.
- REG3 0x0C CFG1 RW.
- REG4 0x10 SAMPLE RO: {16'h0, last sample}.
- REG5 0x14 COUNT RO: 32-bit sample count.
- 0x18 and 0x1C unmapped.
REQ-006 Write channel SHALL be an idle/accept/resp FSM:
- IDLE: when AWVALID and WVALID are both high and BVALID is low, assert AWREADY and WREADY together for exactly one cycle, then go to RESP.
- Address without data (or data without address) SHALL NOT be accepted.
REQ-007 The register update SHALL occur on the same edge as AW/W acceptance, per byte lane where WSTRB[n]=1.
REQ-008 BVALID SHALL rise the cycle after acceptance and hold until BREADY is sampled high; the FSM then returns to IDLE; minimum 3 cycles per write.
REQ-009 BRESP SHALL be OKAY (2'b00) for 0x00-0x14 and SLVERR (2'b10) for unmapped addresses.
REQ-010 Writes to REG4, REG5 and unmapped addresses SHALL have no register effect.
REQ-011 Read channel SHALL be independent of the write channel:
- When ARVALID is high and RVALID is low, pulse ARREADY for one cycle.
- On the next cycle, drive RDATA, RRESP and RVALID, held stable until RREADY is sampled high.
REQ-012 RRESP SHALL be OKAY for mapped addresses; unmapped addresses SHALL return RDATA=0 with SLVERR.
REQ-013 A read accepted on the same edge as a write to the same register SHALL return the pre-write value.
REQ-014 Sample capture:
- When capture_en=1 and adc_valid=1, update REG4[15:0] with adc_data and increment REG5.
- When capture_en=0, adc_valid SHALL be ignored.
REQ-015 REG5 SHALL saturate at 0xFFFFFFFF.
REQ-016 A cnt_clr write SHALL zero REG5 on the acceptance edge; if adc_valid is coincident, the clear wins and REG5=0.
REQ-017 adc_cfg0 and adc_cfg1 SHALL update on the write-acceptance edge with no extra latency.
REQ-018 Read data for REG4/REG5 SHALL be sampled on the ARREADY edge; captures after that edge SHALL NOT alter the held RDATA.

Reset
REQ-019 While S_AXI_ARESETN=0, asynchronously:
- All READY/VALID outputs SHALL be 0.
- BRESP, RRESP and RDATA SHALL be 0.
- REG0-REG5, adc_cfg0 and adc_cfg1 SHALL be 0.
- Both FSMs SHALL be in IDLE.
REQ-020 Reset asserted mid-transaction SHALL abort it; no response is issued after release.
REQ-021 The first transaction SHALL be accepted no earlier than the first rising edge after deassertion.

Verification
REQ-022 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> 0x1,0x2,0x3,0x4, all RRESP=OKAY, adc_cfg0=0x3, adc_cfg1=0x4.
REQ-023 Write 0xAABBCCDD with WSTRB=4'b0101 to 0x04 (prior 0) -> read returns 0x00BB00DD.
REQ-024 capture_en=1, then three adc_valid pulses with 0x0123, 0x0456, 0x0789 -> REG4=0x00000789, REG5=3; write CTRL=0x3 -> REG5=0, CTRL reads 0x1.
REQ-025 Write and read to 0x18 -> BRESP=SLVERR; RDATA=0 with RRESP=SLVERR; no register changes.
REQ-026 BREADY/RREADY held low 10 cycles -> BVALID/RVALID and RDATA stay stable, and no new AW/AR is accepted.
REQ-027 Assert reset during BVALID -> all outputs 0 immediately; after release, a fresh write completes normally.
